// File: rtl/sdio_rx_block_assembler.sv
// SD DAT[3:0] receive assembler: start detect, byte assembly, per-line CRC16 and end-bit check.
// Optional feature macro: SDIO_RX_CRC_EN builds the four CRC16 line checkers; otherwise crc_err is 0.
module sdio_rx_block_assembler #(
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       sd_clk,
  input  logic       sd_rst,
  input  logic       rx_en,
  input  logic [3:0] nib_in,
  input  logic       nib_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  output logic       blk_done,
  output logic       busy,
  output logic       crc_err,
  output logic       end_err,
  output logic       timeout_err,
  output logic       ovf_err
);

  localparam int NW = $clog2(2*BLOCK_BYTES+16);
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  localparam logic [NW-1:0] LAST_DATA_NIB = NW'(2*BLOCK_BYTES-1);
  localparam logic [NW-1:0] LAST_CRC_NIB  = NW'(2*BLOCK_BYTES+15);
  localparam logic [TW-1:0] TIMEOUT_VAL   = TW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DATA,
    S_CRC,
    S_END,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [NW-1:0] nib_q;
  logic [TW-1:0] tcnt_q;
  logic [3:0]    hi_q;
  logic [7:0]    out_data_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          blk_done_q;
  logic          end_err_q;
  logic          timeout_err_q;
  logic          ovf_err_q;

  logic [7:0]    byte_d;
  logic [TW-1:0] tcnt_d;
  logic          handshake;

  assign byte_d    = {hi_q, nib_in};
  assign tcnt_d    = tcnt_q + TW'(1);
  assign handshake = out_valid_q && out_ready;

  // Counters stop at their terminal values; the state change is what ends each phase.
  always_ff @(posedge sd_clk) begin
    if (sd_rst) begin
      state_q       <= S_IDLE;
      nib_q         <= '0;
      tcnt_q        <= '0;
      hi_q          <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      blk_done_q    <= 1'b0;
      end_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      ovf_err_q     <= 1'b0;
    end else begin
      blk_done_q <= 1'b0;
      if (handshake) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (rx_en) begin
            end_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            ovf_err_q     <= 1'b0;
            nib_q         <= '0;
            tcnt_q        <= '0;
            state_q       <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          tcnt_q <= tcnt_d;
          if (nib_valid && (nib_in == 4'h0)) begin
            state_q <= S_DATA;
          end else if (tcnt_d == TIMEOUT_VAL) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        S_DATA: begin
          if (nib_valid) begin
            if (!nib_q[0]) begin
              hi_q <= nib_in;
            end else if (out_valid_q && !out_ready) begin
              ovf_err_q <= 1'b1;
            end else begin
              out_data_q  <= byte_d;
              out_valid_q <= 1'b1;
              out_last_q  <= (nib_q == LAST_DATA_NIB);
            end
            nib_q <= nib_q + NW'(1);
            if (nib_q == LAST_DATA_NIB) begin
              state_q <= S_CRC;
            end
          end
        end
        S_CRC: begin
          if (nib_valid) begin
            if (nib_q == LAST_CRC_NIB) begin
              state_q <= S_END;
            end else begin
              nib_q <= nib_q + NW'(1);
            end
          end
        end
        S_END: begin
          if (nib_valid) begin
            if (nib_in != 4'hF) begin
              end_err_q <= 1'b1;
            end
            blk_done_q <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SDIO_RX_CRC_EN
  logic [15:0] crc_q [4];
  logic [15:0] crc_d [4];
  logic        crc_mis;
  logic        crc_err_q;

  // During the CRC phase each register is shifted out MSB-first against the received line bit.
  always_comb begin
    crc_mis = 1'b0;
    for (int i = 0; i < 4; i++) begin
      crc_d[i] = {crc_q[i][14:0], 1'b0} ^ ((crc_q[i][15] ^ nib_in[i]) ? 16'h1021 : 16'h0000);
      if (crc_q[i][15] != nib_in[i]) begin
        crc_mis = 1'b1;
      end
    end
  end

  always_ff @(posedge sd_clk) begin
    if (sd_rst) begin
      for (int i = 0; i < 4; i++) begin
        crc_q[i] <= '0;
      end
      crc_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_en) begin
            for (int i = 0; i < 4; i++) begin
              crc_q[i] <= '0;
            end
            crc_err_q <= 1'b0;
          end
        end
        S_DATA: begin
          if (nib_valid) begin
            for (int i = 0; i < 4; i++) begin
              crc_q[i] <= crc_d[i];
            end
          end
        end
        S_CRC: begin
          if (nib_valid) begin
            if (crc_mis) begin
              crc_err_q <= 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
              crc_q[i] <= {crc_q[i][14:0], 1'b0};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign blk_done    = blk_done_q;
  assign busy        = (state_q != S_IDLE);
  assign end_err     = end_err_q;
  assign timeout_err = timeout_err_q;
  assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_sdio_rx_block_assembler.sv
// Self-checking bench for sdio_rx_block_assembler (BLOCK_BYTES=4, TIMEOUT_CYC=16).
// CRC expectations follow SDIO_RX_CRC_EN if the bench is compiled with it.
module tb_sdio_rx_block_assembler;

  localparam int BB = 4;
  localparam int TO = 16;
  localparam int DN = 2*BB;
`ifdef SDIO_RX_CRC_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif

  logic       sd_clk = 1'b0;
  logic       sd_rst;
  logic       rx_en;
  logic [3:0] nib_in;
  logic       nib_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       blk_done;
  logic       busy;
  logic       crc_err;
  logic       end_err;
  logic       timeout_err;
  logic       ovf_err;

  int checks = 0;
  int failures = 0;
  int doneCount = 0;
  logic [7:0] gotQ[$];
  logic       gotLastQ[$];
  logic [7:0] expQ[$];
  logic       expLastQ[$];

  logic [7:0] obsData [DN];
  logic       obsOvf [DN];
  logic       obsCrcErr [16];
  logic       obsEndErr;
  logic       obsDone;
  logic       obsDoneAfter;
  logic       obsBusyAfter;

  sdio_rx_block_assembler #(.BLOCK_BYTES(BB), .TIMEOUT_CYC(TO)) dut (
    .sd_clk(sd_clk), .sd_rst(sd_rst), .rx_en(rx_en), .nib_in(nib_in),
    .nib_valid(nib_valid), .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .blk_done(blk_done),
    .busy(busy), .crc_err(crc_err), .end_err(end_err),
    .timeout_err(timeout_err), .ovf_err(ovf_err)
  );

  always #5 sd_clk = ~sd_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: a handshake is logged when valid&&ready were both high before the edge.
  task automatic tick();
    logic       hs;
    logic [7:0] d;
    logic       l;
    hs = out_valid && out_ready;
    d  = out_data;
    l  = out_last;
    @(posedge sd_clk);
    #1;
    if (hs) begin
      gotQ.push_back(d);
      gotLastQ.push_back(l);
    end
    if (blk_done) doneCount++;
  endtask

  task automatic arm();
    rx_en = 1'b1;
    tick();
    rx_en = 1'b0;
  endtask

  task automatic sendNib(input logic [3:0] n, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        nib_valid = 1'b0;
        nib_in    = 4'($urandom);
        tick();
      end
    end
    nib_valid = 1'b1;
    nib_in    = n;
    tick();
    nib_valid = 1'b0;
  endtask

  // Line CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] crcModel(input logic [31:0] bytesIn, input int line);
    logic [DN+15:0] v;
    logic [3:0]     nib;
    v = '0;
    for (int n = 0; n < DN; n++) begin
      nib = bytesIn[8*(BB-1-n/2) + 4*(1-n%2) +: 4];
      v[DN+15-n] = nib[line];
    end
    for (int p = DN+15; p >= 16; p--) begin
      if (v[p]) v[p -: 17] = v[p -: 17] ^ 17'h11021;
    end
    return v[15:0];
  endfunction

  task automatic applyStimulus(input logic [31:0] bytesIn, input int flipLine,
                               input int flipBit, input logic [3:0] endNib, input bit gaps);
    logic [15:0] crcs [4];
    logic [7:0]  b;
    logic [3:0]  nib;
    arm();
    sendNib(4'h0, gaps);
    for (int n = 0; n < DN; n++) begin
      b   = bytesIn[8*(BB-1-n/2) +: 8];
      nib = (n % 2 == 0) ? b[7:4] : b[3:0];
      sendNib(nib, gaps);
      obsData[n] = out_data;
      obsOvf[n]  = ovf_err;
    end
    for (int i = 0; i < 4; i++) begin
      crcs[i] = crcModel(bytesIn, i);
      if (i == flipLine) crcs[i][flipBit] = ~crcs[i][flipBit];
    end
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) nib[i] = crcs[i][15-k];
      sendNib(nib, gaps);
      obsCrcErr[k] = crc_err;
    end
    sendNib(endNib, gaps);
    obsEndErr = end_err;
    obsDone   = blk_done;
    tick();
    obsDoneAfter = blk_done;
    obsBusyAfter = busy;
  endtask

  task automatic expectBytes(input logic [31:0] bytesIn);
    expQ.delete();
    expLastQ.delete();
    gotQ.delete();
    gotLastQ.delete();
    for (int j = 0; j < BB; j++) begin
      expQ.push_back(bytesIn[8*(BB-1-j) +: 8]);
      expLastQ.push_back(j == BB-1);
    end
  endtask

  task automatic checkStream(input string tag);
    checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      checkOutput($sformatf("%s_byte%0d", tag, i), gotQ[i], expQ[i]);
      checkOutput($sformatf("%s_last%0d", tag, i), gotLastQ[i], expLastQ[i]);
    end
  endtask

  task automatic runClean(input string tag, input logic [31:0] bytesIn, input bit gaps);
    int d0;
    expectBytes(bytesIn);
    d0 = doneCount;
    applyStimulus(bytesIn, -1, 0, 4'hF, gaps);
    checkStream(tag);
    checkOutput({tag, "_done_pulses"}, doneCount - d0, 1);
    checkOutput({tag, "_done_then_low"}, {obsDone, obsDoneAfter}, 2'b10);
    checkOutput({tag, "_errs"}, {crc_err, end_err, timeout_err, ovf_err}, 4'b0000);
    checkOutput({tag, "_busy_after"}, obsBusyAfter, 1'b0);
  endtask

  initial begin
    logic [31:0] rb;
    int d0;
    sd_rst = 1'b1; rx_en = 1'b0; nib_in = 4'h0; nib_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    checkOutput("reset_outputs",
                {out_data, out_valid, out_last, blk_done, busy, crc_err, end_err, timeout_err, ovf_err},
                '0);
    sd_rst = 1'b0;
    tick();

    $display("[TB] nominal block");
    runClean("nominal", 32'h12345678, 1'b0);
    $display("[TB] back-to-back nominal block");
    runClean("b2b", 32'hA5C3_0FF0, 1'b0);

    $display("[TB] CRC fault on line 2 bit 15");
    d0 = doneCount;
    applyStimulus(32'h12345678, 2, 15, 4'hF, 1'b0);
    checkOutput("crc_err_first_nib", obsCrcErr[0], CRC_EN);
    checkOutput("crc_err_sticky", crc_err, CRC_EN);
    checkOutput("crc_fault_done", obsDone, 1'b1);
    checkOutput("crc_fault_done_pulses", doneCount - d0, 1);
    checkOutput("crc_fault_end_err", end_err, 1'b0);

    $display("[TB] end-bit fault");
    applyStimulus(32'h12345678, -1, 0, 4'hE, 1'b0);
    checkOutput("end_err_with_done", {obsEndErr, obsDone}, 2'b11);
    checkOutput("end_fault_crc_cleared", crc_err, 1'b0);

    $display("[TB] timeout");
    d0 = doneCount;
    arm();
    checkOutput("timeout_armed_clear", {busy, end_err}, 2'b10);
    nib_valid = 1'b1;
    nib_in    = 4'hF;
    repeat (TO-1) tick();
    checkOutput("timeout_not_yet", {timeout_err, busy}, 2'b01);
    tick();
    checkOutput("timeout_hit", {timeout_err, busy}, 2'b10);
    nib_valid = 1'b0;
    tick();
    checkOutput("timeout_no_done", doneCount - d0, 0);

    $display("[TB] backpressure");
    gotQ.delete();
    gotLastQ.delete();
    out_ready = 1'b0;
    applyStimulus(32'h12345678, -1, 0, 4'hF, 1'b0);
    checkOutput("bp_first_byte", obsData[1], 8'h12);
    checkOutput("bp_no_ovf_yet", obsOvf[1], 1'b0);
    checkOutput("bp_held_byte", obsData[3], 8'h12);
    checkOutput("bp_ovf_on_second", obsOvf[3], 1'b1);
    checkOutput("bp_no_handshake", gotQ.size(), 0);
    checkOutput("bp_still_valid", {out_valid, out_data}, {1'b1, 8'h12});
    out_ready = 1'b1;
    tick();
    checkOutput("bp_one_handshake", gotQ.size(), 1);
    if (gotQ.size() > 0) checkOutput("bp_handshake_byte", gotQ[0], 8'h12);
    checkOutput("bp_drained", out_valid, 1'b0);

    $display("[TB] reset in the middle of DATA");
    arm();
    sendNib(4'h0, 1'b0);
    sendNib(4'h1, 1'b0);
    sendNib(4'h2, 1'b0);
    sendNib(4'h3, 1'b0);
    sd_rst = 1'b1;
    tick();
    checkOutput("midrst_outputs",
                {out_data, out_valid, out_last, blk_done, busy, crc_err, end_err, timeout_err, ovf_err},
                '0);
    sd_rst = 1'b0;
    tick();
    runClean("after_rst", 32'h12345678, 1'b0);

    $display("[TB] randomized blocks with stalls");
    for (int r = 0; r < 4; r++) begin
      rb = $urandom;
      runClean($sformatf("rand%0d", r), rb, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdio_rx_block_assembler.md
# sdio_rx_block_assembler

Receive-side stage downstream of `sdio_data_handler`. It consumes the 4-bit nibbles that the data handler samples from the SD DAT[3:0] lines. It detects the start nibble and assembles `BLOCK_BYTES` data bytes, high nibble first. It checks the per-line CRC16 and end bit, and presents the bytes on a valid/ready byte stream toward the AXI-side buffer.

## Interface
- `BLOCK_BYTES`, 512: data bytes per block; legal range 1..2048.
- `TIMEOUT_CYC`, 65535: sd_clk cycles to wait for the start nibble; legal range 1..65535.
- `sd_clk` in 1: the single clock; all logic samples on its rising edge.
- `sd_rst` in 1: synchronous, active-high reset.
- `rx_en` in 1: 1-cycle arm pulse; ignored while `busy`=1.
- `nib_in` in 4: DAT[3:0] nibble from the data handler.
- `nib_valid` in 1: `nib_in` is valid this cycle.
- `out_ready` in 1: downstream accepts `out_data`.
- `out_data` out 8: assembled byte.
- `out_valid` out 1: `out_data` holds a byte.
- `out_last` out 1: qualifies the final byte of the block.
- `blk_done` out 1: 1-cycle pulse at block end.
- `busy` out 1: high in every state except IDLE.
- `crc_err`, `end_err`, `timeout_err`, `ovf_err` out 1 each: sticky error flags; cleared on `rx_en` accept or reset.

## Operation
- Reset state of every output: 0. After reset the FSM is in IDLE with all counters and CRC registers at 0.
- **IDLE**: on `rx_en`:
  - clear errors, nibble counter, timeout counter and CRCs;
  - go to WAIT_START.
- **WAIT_START**:
  - Timeout counter increments every cycle, whether or not `nib_valid` is high.
  - `nib_valid` with `nib_in`=4'h0 moves to DATA.
  - `nib_valid` with any other value is ignored.
  - Counter reaching `TIMEOUT_CYC` sets `timeout_err` and returns to IDLE. No `blk_done` is issued.
- **DATA**: each valid nibble is handled as follows:
  - Even nibble index: latched as byte[7:4].
  - Odd nibble index: completes the byte.
  - CRC line i shifts in `nib_in[i]`. Per line: CRC16, poly 0x1021, init 0, no reflection: `c <= {c[14:0],0} ^ ((c[15]^bit) ? 16'h1021 : 0)`.
  - After nibble 2*`BLOCK_BYTES`-1, go to CRC.
- **CRC**: 16 valid nibbles.
  - Nibble k carries bit 15-k of each line's CRC; line i is on `nib_in[i]`.
  - Any mismatch sets `crc_err`.
  - After the 16th nibble, go to END.
- **END**: the next valid nibble must be 4'hF; any other value sets `end_err`. Go to DONE.
- **DONE**: `blk_done`=1 for this cycle, then IDLE.
- Output register: one entry.
  - A completed byte loads `out_data`/`out_valid`; `out_last`=1 for the byte with index `BLOCK_BYTES`-1.
  - A handshake occurs at an edge where `out_valid`&&`out_ready`.
  - If a byte completes while `out_valid`=1 and `out_ready`=0, set `ovf_err` and drop the new byte. The held byte is kept.
  - Completion in the same cycle as a handshake is not an overflow: the new byte replaces the old one.
- Nibble counter width: $clog2(2*`BLOCK_BYTES`+16). Counters never wrap: each state exits at its terminal count.
- `nib_valid`=0 stalls DATA, CRC and END indefinitely. The timeout applies only in WAIT_START.
- Reset mid-block: immediate return to IDLE with all outputs at 0. The partial byte and the held output byte are discarded.

## Timing
- The byte appears on `out_valid` on the edge that samples its low nibble: 1-cycle latency from the low-nibble `nib_valid` cycle to visible `out_valid`.
- `crc_err` is set on the edge sampling the mismatching CRC nibble.
- `end_err` and `blk_done` are asserted on the edge sampling the end nibble. `blk_done` deasserts on the following edge.
- `timeout_err` is set on the edge where the timeout count equals `TIMEOUT_CYC`: `TIMEOUT_CYC` cycles after the `rx_en` edge.
- A back-to-back `rx_en` is accepted in the cycle after DONE (IDLE).

## Configuration
- `SDIO_RX_CRC_EN` defined:
  - Four CRC16 line registers are built.
  - CRC state compares the received CRC nibbles as described above.
- Not defined:
  - CRC registers are removed.
  - CRC state still consumes 16 nibbles without checking them.
  - `crc_err` is tied to 0.

## Test plan
- Test parameters: `BLOCK_BYTES`=4, `TIMEOUT_CYC`=16.
- Nominal block: start 0; bytes 0x12, 0x34, 0x56, 0x78; CRCs from the bench model; end F; `out_ready`=1. Required: bytes out in order, `out_last` only with 0x78, one `blk_done` pulse, all errors 0.
- CRC fault: as nominal, with line-2 bit 15 of the CRC inverted. Required: `crc_err`=1 on the first CRC nibble's edge and `blk_done` still pulses. With `SDIO_RX_CRC_EN` undefined, `crc_err`=0.
- End-bit fault: end nibble 4'hE. Required: `end_err`=1 and `blk_done`=1 on the same edge.
- Timeout: `rx_en`, then only `nib_valid` with 4'hF. Required: `timeout_err`=1 exactly 16 cycles later, `busy`=0, no `blk_done`.
- Backpressure: `out_ready`=0 for the whole block. Required: `out_data`=0x12 held and `ovf_err`=1 when 0x34 completes. Raising `out_ready` then gives one handshake of 0x12.
- Reset mid-DATA: `sd_rst` after 3 data nibbles. Required: all outputs 0 next cycle. A subsequent nominal block passes cleanly.
